ahbl_sram_port: RTL and testbench
=================================

// Module: ahbl_sram_port
//
// PURPOSE
// AHB-Lite subordinate that drives one sram_wrapper instance, giving zero-wait-state
// reads and writes. AHB write data arrives one cycle after the address, and a read
// address phase may want the SRAM in that same cycle. A one-entry write buffer
// resolves that collision. Reads that hit the buffer have their data merged at byte
// granularity. Sits between the bus fabric splitter and the SRAM macros.
//
// PARAMETERS
// W_ADDR  32   AHB address width
// W_DATA  32   AHB/SRAM data width; multiple of 8
// DEPTH   512  SRAM depth in words; addr bits above $clog2(DEPTH)+$clog2(W_DATA/8) ignored
//
// PORTS
// clk                clk    input   1                 clock
// rst                rst    input   1                 sync reset, active-high
// ahbls_hready       input   1                 bus-wide ready; qualifies address phase
// ahbls_hready_resp  output  1                 this subordinate's ready
// ahbls_hresp        output  1                 error response
// ahbls_haddr        input   W_ADDR            byte address
// ahbls_hwrite       input   1                 1 = write
// ahbls_htrans       input   2                 transfer type; bit 1 = active (splitter gates select)
// ahbls_hsize        input   3                 0 = byte, 1 = halfword, 2 = word
// ahbls_hwdata       input   W_DATA            write data (data phase)
// ahbls_hrdata       output  W_DATA            read data (data phase)
// sram_cs_n          output  1                 SRAM select, active-low
// sram_we_n          output  1                 SRAM write enable, active-low
// sram_be_n          output  W_DATA/8          SRAM byte enables, active-low
// sram_addr          output  $clog2(DEPTH)     SRAM word address
// sram_wdata         output  W_DATA            SRAM write data
// sram_rdata         input   W_DATA            SRAM read data, valid 1 cycle after read select
//
// BEHAVIOUR
// - Responses: ahbls_hready_resp = 1 and ahbls_hresp = 0 at all times, including in reset.
// - Transfer accept: aph = ahbls_hready & ahbls_htrans[1]. read_aph = aph & !hwrite;
//   write_aph = aph & hwrite.
// - Byte mask: derived from hsize and haddr[1:0].
//   - byte: lane haddr[1:0]
//   - halfword: lanes {haddr[1],0} and {haddr[1],1}
//   - word: all lanes
//   - Misaligned transfers are undefined.
// - Data-phase state registers (on aph): dph_read, dph_write, dph_addr, dph_mask.
//   Cleared when hready = 1 and no aph.
// - SRAM port priority, evaluated combinationally each cycle:
//   1. read_aph: cs_n = 0, we_n = 1, addr = haddr word index.
//   2. else if dph_write: cs_n = 0, we_n = 0, addr = dph_addr, be_n = ~dph_mask,
//      wdata = hwdata (direct write).
//   3. else if wbuf_valid: cs_n = 0, we_n = 0, addr/be_n/wdata from buffer (drain);
//      wbuf_valid clears at clock edge.
//   4. else cs_n = 1, we_n = 1.
// - Buffer fill: on dph_write & read_aph, capture wbuf_addr = dph_addr,
//   wbuf_mask = dph_mask, wbuf_data = hwdata, and set wbuf_valid.
// - Invariant: wbuf_valid is never 1 during a dph_write cycle. A filled buffer is
//   followed only by read data phases until the first non-read cycle, which drains it.
//   Verification asserts this invariant; there is no overflow path.
// - Read data: hrdata = sram_rdata, with lanes replaced by wbuf_data where
//   wbuf_valid & (wbuf_addr == dph_addr) & wbuf_mask[lane].
//   - Covers read-after-write in back-to-back cycles to the same word.
//   - hrdata is don't-care outside read data phases.
// - Addresses beyond DEPTH alias (upper bits dropped); no error response.
// - Reset: sync, clears dph_read, dph_write, and wbuf_valid.
//   - Outputs during and after reset: sram_cs_n = 1, sram_we_n = 1,
//     sram_be_n = all 1s, hready_resp = 1, hresp = 0.
//   - Reset mid-operation discards any buffered write (the SRAM is not written).
//   - The first cycle after reset is idle.
//
// TESTING
// 1. Word write 0x100 = 0xDEADBEEF, idle, read 0x100
//    -> hrdata = 0xDEADBEEF; one SRAM write cycle with be_n = 0000.
// 2. Write 0x40 = 0x11223344 with the next aph a read of 0x40
//    -> buffer fills; read returns 0x11223344 (merged); the buffer drains on the
//    first idle cycle.
// 3. Byte writes 0x81 = 0xAA and 0x82 = 0xBB, then word read 0x80 over init 0
//    -> hrdata = 0x00BBAA00; be_n sequence 1101, 1011.
// 4. Write 0x10, then 3 consecutive reads of 0x10, 0x14, 0x10
//    -> all reads zero-wait; the 0x10 reads see the merged data; the drain occurs
//    after the last read.
// 5. Assert rst while wbuf_valid
//    -> no SRAM write issued; cs_n = 1 while rst is asserted; a later read returns
//    the old SRAM contents.
// 6. Random AHB traffic vs. reference memory model
//    -> hready_resp always 1; the wbuf_valid & dph_write assertion never fires.

Source files
------------

// File: rtl/ahbl_sram_port.sv
// AHB-Lite subordinate giving zero-wait-state access to one single-port SRAM.
// A one-entry write buffer absorbs the write data phase when a read address phase wants the SRAM.
module ahbl_sram_port #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ahbls_hready,
    output logic                        ahbls_hready_resp,
    output logic                        ahbls_hresp,
    input  logic [W_ADDR-1:0]           ahbls_haddr,
    input  logic                        ahbls_hwrite,
    input  logic [1:0]                  ahbls_htrans,
    input  logic [2:0]                  ahbls_hsize,
    input  logic [W_DATA-1:0]           ahbls_hwdata,
    output logic [W_DATA-1:0]           ahbls_hrdata,
    output logic                        sram_cs_n,
    output logic                        sram_we_n,
    output logic [W_DATA/8-1:0]         sram_be_n,
    output logic [$clog2(DEPTH)-1:0]    sram_addr,
    output logic [W_DATA-1:0]           sram_wdata,
    input  logic [W_DATA-1:0]           sram_rdata
);

    localparam int unsigned W_BYTES = W_DATA / 8;
    localparam int unsigned W_OFF   = $clog2(W_BYTES);
    localparam int unsigned W_SADDR = $clog2(DEPTH);

    logic                 aph_c;
    logic                 read_aph_c;
    logic [W_SADDR-1:0]   aph_addr_c;
    logic [W_BYTES-1:0]   aph_mask_c;
    logic                 wbuf_hit_c;
    logic                 unused_c;

    logic                 dph_read_q,   dph_read_d;
    logic                 dph_write_q,  dph_write_d;
    logic [W_SADDR-1:0]   dph_addr_q,   dph_addr_d;
    logic [W_BYTES-1:0]   dph_mask_q,   dph_mask_d;
    logic                 wbuf_valid_q, wbuf_valid_d;
    logic [W_SADDR-1:0]   wbuf_addr_q,  wbuf_addr_d;
    logic [W_BYTES-1:0]   wbuf_mask_q,  wbuf_mask_d;
    logic [W_DATA-1:0]    wbuf_data_q,  wbuf_data_d;

    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;

    assign aph_c      = ahbls_hready & ahbls_htrans[1];
    assign read_aph_c = aph_c & ~ahbls_hwrite;
    assign aph_addr_c = ahbls_haddr[W_OFF +: W_SADDR];
    assign unused_c   = ^{ahbls_haddr[W_ADDR-1:W_OFF+W_SADDR], ahbls_htrans[0]};

    // A lane is enabled when it agrees with the address offset on every bit at or above hsize
    always_comb begin
        aph_mask_c = '0;
        for (int unsigned i = 0; i < W_BYTES; i++) begin
            aph_mask_c[i] = ((W_OFF'(i) ^ ahbls_haddr[W_OFF-1:0]) >> ahbls_hsize) == '0;
        end
    end

    // Data-phase tracking and write-buffer fill/drain
    always_comb begin
        dph_read_d   = dph_read_q;
        dph_write_d  = dph_write_q;
        dph_addr_d   = dph_addr_q;
        dph_mask_d   = dph_mask_q;
        wbuf_valid_d = wbuf_valid_q;
        wbuf_addr_d  = wbuf_addr_q;
        wbuf_mask_d  = wbuf_mask_q;
        wbuf_data_d  = wbuf_data_q;

        if (aph_c) begin
            dph_read_d  = ~ahbls_hwrite;
            dph_write_d = ahbls_hwrite;
            dph_addr_d  = aph_addr_c;
            dph_mask_d  = aph_mask_c;
        end else if (ahbls_hready) begin
            dph_read_d  = 1'b0;
            dph_write_d = 1'b0;
        end

        if (dph_write_q && read_aph_c) begin
            wbuf_valid_d = 1'b1;
            wbuf_addr_d  = dph_addr_q;
            wbuf_mask_d  = dph_mask_q;
            wbuf_data_d  = ahbls_hwdata;
        end else if (!read_aph_c && !dph_write_q) begin
            wbuf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dph_read_q   <= 1'b0;
            dph_write_q  <= 1'b0;
            wbuf_valid_q <= 1'b0;
        end else begin
            dph_read_q   <= dph_read_d;
            dph_write_q  <= dph_write_d;
            wbuf_valid_q <= wbuf_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        dph_addr_q  <= dph_addr_d;
        dph_mask_q  <= dph_mask_d;
        wbuf_addr_q <= wbuf_addr_d;
        wbuf_mask_q <= wbuf_mask_d;
        wbuf_data_q <= wbuf_data_d;
    end

    // SRAM port arbitration: read address phase, then direct write, then buffer drain
    always_comb begin
        sram_cs_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = '1;
        sram_addr  = aph_addr_c;
        sram_wdata = ahbls_hwdata;
        if (!rst) begin
            if (read_aph_c) begin
                sram_cs_n = 1'b0;
            end else if (dph_write_q) begin
                sram_cs_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_addr  = dph_addr_q;
                sram_be_n  = ~dph_mask_q;
            end else if (wbuf_valid_q) begin
                sram_cs_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_addr  = wbuf_addr_q;
                sram_be_n  = ~wbuf_mask_q;
                sram_wdata = wbuf_data_q;
            end
        end
    end

    // Buffered bytes not yet in the SRAM override the stale read lanes
    assign wbuf_hit_c = wbuf_valid_q & dph_read_q & (wbuf_addr_q == dph_addr_q);

    always_comb begin
        ahbls_hrdata = sram_rdata;
        for (int unsigned i = 0; i < W_BYTES; i++) begin
            if (wbuf_hit_c && wbuf_mask_q[i]) begin
                ahbls_hrdata[8*i +: 8] = wbuf_data_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_sram_port.sv
// Directed and random checks of ahbl_sram_port against a behavioural SRAM and a byte-level memory model.
module tb_ahbl_sram_port;

    localparam int unsigned DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        hready;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        sram_cs_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    int tests    = 0;
    int fails    = 0;
    int wr_count = 0;
    int resp_err = 0;
    int inv_err  = 0;

    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    ahbl_sram_port dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .sram_cs_n         (sram_cs_n),
        .sram_we_n         (sram_we_n),
        .sram_be_n         (sram_be_n),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_rdata        (sram_rdata)
    );

    // Behavioural SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (!sram_cs_n) begin
            if (!sram_we_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (!sram_be_n[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
                wr_count <= wr_count + 1;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (hready_resp !== 1'b1 || hresp !== 1'b0) resp_err = resp_err + 1;
        if (dut.wbuf_valid_q === 1'b1 && dut.dph_write_q === 1'b1) inv_err = inv_err + 1;
    end

    // One bus cycle: apply address phase and write data after the edge, return at the next falling edge
    task automatic drive(input logic act, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        htrans = act ? 2'b10 : 2'b00;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        hwdata = wdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 3'd2, 32'h0);
        drive(1'b1, 1'b1, 32'h4, 3'd2, 32'h0);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n} !== 6'b11_1111) begin
            fails++;
            $display("FAIL reset_sram got %b want 111111", {sram_cs_n, sram_we_n, sram_be_n});
        end
        tests++;
        if ({hready_resp, hresp} !== 2'b10) begin
            fails++;
            $display("FAIL reset_resp got %b want 10", {hready_resp, hresp});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        htrans = 2'b00;
        @(negedge clk);
        tests++;
        if ({sram_cs_n, sram_we_n} !== 2'b11) begin
            fails++;
            $display("FAIL reset_first_idle got %b want 11", {sram_cs_n, sram_we_n});
        end
    endtask

    task automatic test_word_write();
        int wr0 = wr_count;
        drive(1'b1, 1'b1, 32'h100, 3'd2, 32'h0);
        tests++;
        if ({sram_cs_n, sram_we_n} !== 2'b11) begin
            fails++;
            $display("FAIL t1_aph_idle got %b want 11", {sram_cs_n, sram_we_n});
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'hDEADBEEF);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n, sram_addr, sram_wdata} !== {6'b00_0000, 9'h040, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL t1_direct_write got %b %h %h want 000000 040 deadbeef",
                     {sram_cs_n, sram_we_n, sram_be_n}, sram_addr, sram_wdata);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        drive(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_addr} !== {2'b01, 9'h040}) begin
            fails++;
            $display("FAIL t1_read_sel got %b %h want 01 040", {sram_cs_n, sram_we_n}, sram_addr);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if (hrdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL t1_rdata got %h want deadbeef", hrdata);
        end
        #1;
        tests++;
        if (wr_count - wr0 !== 1) begin
            fails++;
            $display("FAIL t1_write_count got %0d want 1", wr_count - wr0);
        end
    endtask

    task automatic test_buffer_fill();
        drive(1'b1, 1'b1, 32'h40, 3'd2, 32'h0);
        drive(1'b1, 1'b0, 32'h40, 3'd2, 32'h11223344);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_addr} !== {2'b01, 9'h010}) begin
            fails++;
            $display("FAIL t2_read_wins got %b %h want 01 010", {sram_cs_n, sram_we_n}, sram_addr);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if (hrdata !== 32'h11223344) begin
            fails++;
            $display("FAIL t2_merged_rdata got %h want 11223344", hrdata);
        end
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n, sram_addr, sram_wdata} !== {6'b00_0000, 9'h010, 32'h11223344}) begin
            fails++;
            $display("FAIL t2_drain got %b %h %h want 000000 010 11223344",
                     {sram_cs_n, sram_we_n, sram_be_n}, sram_addr, sram_wdata);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if ({sram_cs_n, sram_we_n} !== 2'b11) begin
            fails++;
            $display("FAIL t2_after_drain got %b want 11", {sram_cs_n, sram_we_n});
        end
        drive(1'b1, 1'b0, 32'h40, 3'd2, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if (hrdata !== 32'h11223344) begin
            fails++;
            $display("FAIL t2_sram_rdata got %h want 11223344", hrdata);
        end
    endtask

    task automatic test_byte_lanes();
        drive(1'b1, 1'b1, 32'h81, 3'd0, 32'h0);
        drive(1'b1, 1'b1, 32'h82, 3'd0, 32'h0000AA00);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n, sram_addr} !== {6'b00_1101, 9'h020}) begin
            fails++;
            $display("FAIL t3_be_lane1 got %b %h want 001101 020", {sram_cs_n, sram_we_n, sram_be_n}, sram_addr);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h00BB0000);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n} !== 6'b00_1011) begin
            fails++;
            $display("FAIL t3_be_lane2 got %b want 001011", {sram_cs_n, sram_we_n, sram_be_n});
        end
        drive(1'b1, 1'b0, 32'h80, 3'd2, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if (hrdata !== 32'h00BBAA00) begin
            fails++;
            $display("FAIL t3_rdata got %h want 00bbaa00", hrdata);
        end
    endtask

    task automatic test_back_to_back();
        int wr0 = wr_count;
        drive(1'b1, 1'b1, 32'h10, 3'd2, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 3'd2, 32'hCAFEF00D);
        drive(1'b1, 1'b0, 32'h14, 3'd2, 32'h0);
        tests++;
        if ({hrdata, hready_resp, sram_cs_n, sram_we_n, sram_addr} !== {32'hCAFEF00D, 3'b101, 9'h005}) begin
            fails++;
            $display("FAIL t4_read1 got %h %b %h want cafef00d 101 005",
                     hrdata, {hready_resp, sram_cs_n, sram_we_n}, sram_addr);
        end
        drive(1'b1, 1'b0, 32'h10, 3'd2, 32'h0);
        tests++;
        if ({hrdata, hready_resp, sram_cs_n, sram_we_n, sram_addr} !== {32'h0, 3'b101, 9'h004}) begin
            fails++;
            $display("FAIL t4_read2 got %h %b %h want 00000000 101 004",
                     hrdata, {hready_resp, sram_cs_n, sram_we_n}, sram_addr);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if (hrdata !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL t4_read3 got %h want cafef00d", hrdata);
        end
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n, sram_addr} !== {6'b00_0000, 9'h004}) begin
            fails++;
            $display("FAIL t4_drain got %b %h want 000000 004", {sram_cs_n, sram_we_n, sram_be_n}, sram_addr);
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        #1;
        tests++;
        if (wr_count - wr0 !== 1) begin
            fails++;
            $display("FAIL t4_write_count got %0d want 1", wr_count - wr0);
        end
    endtask

    task automatic test_reset_discard();
        int wr0 = wr_count;
        drive(1'b1, 1'b1, 32'h20, 3'd2, 32'h0);
        drive(1'b1, 1'b0, 32'h24, 3'd2, 32'h55555555);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        htrans = 2'b00;
        @(negedge clk);
        tests++;
        if ({sram_cs_n, sram_we_n, sram_be_n, hready_resp, hresp} !== 8'b11_1111_10) begin
            fails++;
            $display("FAIL t5_in_reset got %b want 11111110",
                     {sram_cs_n, sram_we_n, sram_be_n, hready_resp, hresp});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        #1;
        tests++;
        if (wr_count - wr0 !== 0) begin
            fails++;
            $display("FAIL t5_no_write got %0d want 0", wr_count - wr0);
        end
        drive(1'b1, 1'b0, 32'h20, 3'd2, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        tests++;
        if (hrdata !== 32'h0) begin
            fails++;
            $display("FAIL t5_old_data got %h want 00000000", hrdata);
        end
    endtask

    function automatic logic lane_on(input int lane, input logic [5:0] off, input logic [2:0] size);
        case (size)
            3'd0:    lane_on = (lane == int'(off[1:0]));
            3'd1:    lane_on = ((lane / 2) == int'(off[1]));
            default: lane_on = 1'b1;
        endcase
    endfunction

    task automatic test_random();
        logic [7:0]  refb [64];
        logic        act, wr, prev_wr, pend_rd;
        logic [2:0]  size, prev_size;
        logic [5:0]  off, prev_off;
        logic [31:0] wd, exp_rd, pend_exp;
        int          word_base;
        for (int i = 0; i < 64; i++) refb[i] = '0;
        prev_wr   = 1'b0;
        pend_rd   = 1'b0;
        prev_off  = '0;
        prev_size = '0;
        pend_exp  = '0;
        for (int n = 0; n < 300; n++) begin
            act  = ($urandom_range(0, 3) != 0);
            wr   = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 2));
            off  = 6'($urandom_range(0, 63));
            off  = off & ~6'((1 << size) - 1);
            wd   = $urandom();
            if (prev_wr) begin
                word_base = int'(prev_off) & ~3;
                for (int l = 0; l < 4; l++) begin
                    if (lane_on(l, prev_off, prev_size)) refb[word_base + l] = wd[8*l +: 8];
                end
            end
            word_base = int'(off) & ~3;
            exp_rd = {refb[word_base + 3], refb[word_base + 2], refb[word_base + 1], refb[word_base]};
            drive(act, wr, 32'h400 + {26'h0, off}, size, wd);
            if (pend_rd) begin
                tests++;
                if (hrdata !== pend_exp) begin
                    fails++;
                    $display("FAIL t6_rdata cycle %0d got %h want %h", n, hrdata, pend_exp);
                end
            end
            pend_rd   = act & ~wr;
            pend_exp  = exp_rd;
            prev_wr   = act & wr;
            prev_off  = off;
            prev_size = size;
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, $urandom());
        if (pend_rd) begin
            tests++;
            if (hrdata !== pend_exp) begin
                fails++;
                $display("FAIL t6_rdata_last got %h want %h", hrdata, pend_exp);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
        #1;
        tests++;
        if (resp_err !== 0) begin
            fails++;
            $display("FAIL t6_hready_resp violations got %0d want 0", resp_err);
        end
        tests++;
        if (inv_err !== 0) begin
            fails++;
            $display("FAIL t6_wbuf_invariant violations got %0d want 0", inv_err);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        rst    = 1'b1;
        hready = 1'b1;
        haddr  = '0;
        hwrite = 1'b0;
        htrans = 2'b00;
        hsize  = 3'd2;
        hwdata = '0;
        test_reset();
        test_word_write();
        test_buffer_fill();
        test_byte_lanes();
        test_back_to_back();
        test_reset_discard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
